instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encoder counterpart of the control decoder: converts field-level instruction requests into 32-bit MIPS words and writes them sequentially into instruction memory.
- Used by the bench and boot path to load programs before the CPU is released from reset.
- Handles the same op set the decoder recognises: R-type, addi, sltiu, beq, lui, ori, bne.

Parameters:
- DEPTH, 256, instruction-memory capacity in words; bounds the write count.
- AW, 32, width of the byte address driven to instruction memory.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse; begins a load session at base_addr_i
- base_addr_i  in  AW  byte address of the first word; low 2 bits ignored
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid and ready are both high
- req_op_i  in  3  op code: 0 R_TYPE, 1 ADDI, 2 SLTIU, 3 BEQ, 4 LUI, 5 ORI, 6 BNE, 7 illegal
- req_rs_i  in  5  rs field
- req_rt_i  in  5  rt field
- req_rd_i  in  5  rd field (R-type only)
- req_shamt_i  in  5  shamt field (R-type only)
- req_funct_i  in  6  funct field (R-type only)
- req_imm_i  in  16  immediate / branch offset
- req_last_i  in  1  marks the final request of the session
- im_we_o  out  1  instruction-memory write strobe
- im_addr_o  out  AW  word-aligned byte address
- im_wdata_o  out  32  encoded word
- im_ready_i  in  1  memory accepts the write this cycle
- count_o  out  $clog2(DEPTH)+1  words written this session
- busy_o  out  1  high in LOAD and FLUSH
- done_o  out  1  one-cycle pulse at end of session
- err_o  out  1  sticky: illegal op seen or overflow occurred; cleared by start_i

Behaviour:
- Reset values: all outputs 0; state IDLE; pending write dropped.
- Reset mid-session aborts the session; nothing already written is undone.
- States:
  - IDLE: on start_i -> LOAD; address register <= {base_addr_i[AW-1:2], 2'b00}; count and err cleared. start_i is ignored in every other state.
  - LOAD: req_ready_o = !pend || im_ready_i, where pend is the write-pending flag.
  - On an accepted request with req_last_i = 1 -> FLUSH.
  - FLUSH: req_ready_o = 0; once pend clears (im_ready_i completes the write) -> DONE.
  - DONE: done_o = 1 for exactly one cycle -> IDLE.
- Latency: a request accepted in cycle N drives im_we_o/im_addr_o/im_wdata_o from cycle N+1.
- Outputs are registered and held stable while im_ready_i = 0.
- Each write completes when im_we_o and im_ready_i are both high. On completion: address += 4 (wraps modulo 2^AW), count += 1.
- Back-to-back: a new request is accepted in the same cycle a pending write completes; there are no bubbles.
- Encoding:
  - R_TYPE: {6'b000000, rs, rt, rd, shamt, funct}
  - ADDI: opcode 001000
  - SLTIU: opcode 001011
  - BEQ: opcode 000100
  - LUI: opcode 001111, rs forced to 0
  - ORI: opcode 001101
  - BNE: opcode 000101
  - I-format words are {opcode, rs, rt, imm}. Unused fields are ignored.
- Illegal op (7): the request is accepted and err_o is set; nothing is written and count is unchanged. If req_last_i is set, the session still ends through FLUSH/DONE.
- Overflow: when count + pending writes would exceed DEPTH, the request is accepted but dropped and err_o is set. After that, req_ready_o stays high and all further requests are dropped until last.
- Simultaneous start_i and req_valid_i in IDLE: start wins; requests are not accepted in IDLE (req_ready_o = 0).

Decomposition:
- Shared package: 3-bit op codes (R_TYPE=0 … BNE=6), shared with the decoder's ALU-op constants; 6-bit MIPS opcode constants; the state encoding.
- Sub-module: instr_word_pack, a combinational op+fields -> 32-bit word with an illegal flag. The session FSM and write register stay in instr_encoder.

Test Plan:
- start base 0x40; ADDI rs=1 rt=2 imm=0x0005 last -> one write at addr 0x40, data 0x20220005; count=1; done_o pulse.
- R-type rs=1 rt=2 rd=3 shamt=0 funct=0x20, then BEQ rs=3 rt=0 imm=0xFFFF last -> data 0x00221820 at 0x00, 0x1060FFFF at 0x04; count=2.
- LUI rs=7 rt=4 imm=0x1234 -> data 0x3C041234 (rs forced 0).
- im_ready_i low for 3 cycles with a continuous valid stream -> outputs held, ready low, no word lost or duplicated; order preserved.
- op=7 mid-stream -> err_o=1, no write, following word lands at the next sequential address.
- DEPTH=2, three requests -> two writes, err_o=1, done_o pulse; rst_i mid-LOAD -> busy_o=0 next cycle, im_we_o=0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// instr_encoder_pkg
//   Shared definitions for the instruction encoder:
//   - op_e      : 3-bit request op codes. The numbering matches the ALU-op
//                 constants used by the control decoder.
//   - OPC_*     : 6-bit MIPS primary opcodes for each supported op.
//   - state_e   : load-session state encoding.
//   - pack_iformat : assembles an I-format word {opcode, rs, rt, imm}.
// ---------------------------------------------------------------------------
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        OP_R_TYPE  = 3'd0,
        OP_ADDI    = 3'd1,
        OP_SLTIU   = 3'd2,
        OP_BEQ     = 3'd3,
        OP_LUI     = 3'd4,
        OP_ORI     = 3'd5,
        OP_BNE     = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_BNE   = 6'b000101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] pack_iformat(
        input logic [5:0]  opcode,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opcode, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_word_pack.sv
// ---------------------------------------------------------------------------
// instr_word_pack
//   Purely combinational: turns an op code plus instruction fields into a
//   32-bit MIPS word. Fields an op does not use are ignored.
//
//   Ports
//     op      in   3   request op code (op_e numbering)
//     rs      in   5   rs field
//     rt      in   5   rt field
//     rd      in   5   rd field (R-type only)
//     shamt   in   5   shift amount (R-type only)
//     funct   in   6   function field (R-type only)
//     imm     in  16   immediate / branch offset (I-format only)
//     word    out 32   encoded instruction word (zero when illegal)
//     illegal out  1   op code has no encoding
// ---------------------------------------------------------------------------
module instr_word_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // LUI has no source register, so its rs field is forced to zero even
    // when the request carries a non-zero value.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_e'(op))
            OP_R_TYPE: word = {OPC_RTYPE, rs, rt, rd, shamt, funct};
            OP_ADDI:   word = pack_iformat(OPC_ADDI,  rs,   rt, imm);
            OP_SLTIU:  word = pack_iformat(OPC_SLTIU, rs,   rt, imm);
            OP_BEQ:    word = pack_iformat(OPC_BEQ,   rs,   rt, imm);
            OP_LUI:    word = pack_iformat(OPC_LUI,   5'd0, rt, imm);
            OP_ORI:    word = pack_iformat(OPC_ORI,   rs,   rt, imm);
            OP_BNE:    word = pack_iformat(OPC_BNE,   rs,   rt, imm);
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Accepts field-level instruction requests, encodes them into MIPS words
//   and writes them to consecutive word addresses of instruction memory,
//   starting from a base address given with start_i. Used to load a program
//   before the CPU leaves reset.
//
//   Parameters
//     DEPTH  instruction-memory capacity in words (bounds writes per session)
//     AW     width of the byte address driven to instruction memory
//
//   Ports
//     clk_i, rst_i          clock, synchronous active-high reset
//     start_i, base_addr_i  begin a session at base_addr_i (low 2 bits dropped)
//     req_valid_i/ready_o   request handshake
//     req_op_i .. req_imm_i request op code and instruction fields
//     req_last_i            final request of the session
//     im_we_o/addr_o/wdata_o registered write towards instruction memory
//     im_ready_i            memory takes the write this cycle
//     count_o               words written this session
//     busy_o                session in progress (LOAD or FLUSH)
//     done_o                one-cycle end-of-session pulse
//     err_o                 sticky illegal-op / overflow flag
// ---------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [AW-1:0]           base_addr_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [2:0]              req_op_i,
    input  logic [4:0]              req_rs_i,
    input  logic [4:0]              req_rt_i,
    input  logic [4:0]              req_rd_i,
    input  logic [4:0]              req_shamt_i,
    input  logic [5:0]              req_funct_i,
    input  logic [15:0]             req_imm_i,
    input  logic                    req_last_i,
    output logic                    im_we_o,
    output logic [AW-1:0]           im_addr_o,
    output logic [31:0]             im_wdata_o,
    input  logic                    im_ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIMIT = DEPTH[CW:0];

    state_e          state_q;
    state_e          state_d;

    logic            pend_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [CW-1:0]   count_q;
    logic            err_q;
    logic            ovf_q;

    logic [31:0]     pack_word;
    logic            pack_illegal;

    logic            session_start;
    logic            accept;
    logic            write_done;
    logic            has_room;
    logic            write_new;
    logic            drop_overflow;
    logic [CW:0]     committed;
    logic [1:0]      unused_base_bits;

    assign unused_base_bits = base_addr_i[1:0];

    instr_word_pack u_pack (
        .op      (req_op_i),
        .rs      (req_rs_i),
        .rt      (req_rt_i),
        .rd      (req_rd_i),
        .shamt   (req_shamt_i),
        .funct   (req_funct_i),
        .imm     (req_imm_i),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // Words already written plus the one still waiting on memory. This sum
    // does not change when a pending write completes, so the room check is
    // valid in the same cycle as a completion.
    assign committed     = {1'b0, count_q} + {{CW{1'b0}}, pend_q};
    assign has_room      = committed < DEPTH_LIMIT;

    assign session_start = (state_q == ST_IDLE) && start_i;
    assign accept        = req_valid_i && req_ready_o;
    assign write_done    = pend_q && im_ready_i;
    assign write_new     = accept && !pack_illegal && !ovf_q && has_room;
    assign drop_overflow = accept && !pack_illegal && !ovf_q && !has_room;

    // Session state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake/status outputs. Once overflow has been hit,
    // requests are swallowed regardless of the memory, so ready is forced
    // high until the last request arrives.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy_o      = 1'b1;
                req_ready_o = ovf_q || !pend_q || im_ready_i;
                if (req_valid_i && req_ready_o && req_last_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy_o = 1'b1;
                if (!pend_q || im_ready_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write register, address/count bookkeeping and error flags. The address
    // register always holds the address of the pending (or next) word, so a
    // request accepted in the cycle a write completes lands on the advanced
    // address with no bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (session_start) begin
            addr_q  <= {base_addr_i[AW-1:2], 2'b00};
            count_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (write_done) begin
                addr_q  <= addr_q + AW'(4);
                count_q <= count_q + CW'(1);
            end
            if (write_new) begin
                pend_q  <= 1'b1;
                wdata_q <= pack_word;
            end else if (write_done) begin
                pend_q  <= 1'b0;
            end
            if ((accept && pack_illegal) || drop_overflow) begin
                err_q <= 1'b1;
            end
            if (drop_overflow) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign im_we_o    = pend_q;
    assign im_addr_o  = addr_q;
    assign im_wdata_o = wdata_q;
    assign count_o    = count_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Self-checking bench for instr_encoder (DEPTH = 8 so overflow is cheap to
//   reach). Expected words come from a field-arithmetic model of the MIPS
//   encodings; expected write lists come from a per-session queue model.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int TB_DEPTH = 8;
    localparam int TB_AW    = 32;

    typedef struct {
        bit [2:0]  op;
        bit [4:0]  rs;
        bit [4:0]  rt;
        bit [4:0]  rd;
        bit [4:0]  shamt;
        bit [5:0]  funct;
        bit [15:0] imm;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [5:0]  req_funct;
    logic [15:0] req_imm;
    logic        req_last;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        im_ready;
    logic [3:0]  count;
    logic        busy, done, err;

    int checks   = 0;
    int failures = 0;

    bit [31:0] obs_addr[$], obs_data[$], exp_addr[$], exp_data[$];
    int  exp_count;
    bit  exp_err;
    int  hold_viol = 0, idle_ready_viol = 0, bp_viol = 0;
    bit  expect_bp = 0;
    int  ready_prob = 100;
    int  stall_req = 0;
    int  done_cycles;
    bit  timed_out;
    int  got_count;
    bit  got_err, got_busy;

    instr_encoder #(.DEPTH(TB_DEPTH), .AW(TB_AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base_addr),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_rs_i    (req_rs),
        .req_rt_i    (req_rt),
        .req_rd_i    (req_rd),
        .req_shamt_i (req_shamt),
        .req_funct_i (req_funct),
        .req_imm_i   (req_imm),
        .req_last_i  (req_last),
        .im_we_o     (im_we),
        .im_addr_o   (im_addr),
        .im_wdata_o  (im_wdata),
        .im_ready_i  (im_ready),
        .count_o     (count),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Memory-side ready: scripted stalls take priority over random acceptance.
    initial begin
        im_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall_req > 0) begin
                im_ready = 1'b0;
                stall_req--;
            end else begin
                im_ready = ($urandom_range(0, 99) < ready_prob);
            end
        end
    end

    // Collect completed writes and track stability/handshake invariants.
    bit        prev_stall = 0;
    bit [31:0] prev_addr, prev_data;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (im_we !== 1'b1 || im_addr !== prev_addr || im_wdata !== prev_data))
                hold_viol++;
            if (im_we && im_ready) begin
                obs_addr.push_back(im_addr);
                obs_data.push_back(im_wdata);
            end
            if (!busy && req_ready) idle_ready_viol++;
            if (expect_bp && im_we && !im_ready && req_ready) bp_viol++;
            prev_stall = im_we && !im_ready;
            prev_addr  = im_addr;
            prev_data  = im_wdata;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Reference encoding from instruction-format field positions.
    function automatic bit [31:0] ref_encode(input req_t r);
        bit [31:0] opc[7] = '{0, 8, 11, 4, 15, 13, 5};
        bit [31:0] rs_v = r.rs, rt_v = r.rt, rd_v = r.rd;
        bit [31:0] sh_v = r.shamt, fn_v = r.funct, im_v = r.imm;
        if (r.op == 3'd0)
            return rs_v * 32'd2097152 + rt_v * 32'd65536 + rd_v * 32'd2048 + sh_v * 32'd64 + fn_v;
        if (r.op == 3'd4) rs_v = 0;
        return opc[r.op] * 32'd67108864 + rs_v * 32'd2097152 + rt_v * 32'd65536 + im_v;
    endfunction

    task automatic model_session(input bit [31:0] base, input req_t reqs[$]);
        int n = 0;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 0;
        foreach (reqs[i]) begin
            if (reqs[i].op == 3'd7) begin
                exp_err = 1;
            end else if (n >= TB_DEPTH) begin
                exp_err = 1;
            end else begin
                exp_addr.push_back((base & 32'hFFFF_FFFC) + 32'(4 * n));
                exp_data.push_back(ref_encode(reqs[i]));
                n++;
            end
        end
        exp_count = n;
    endtask

    task automatic set_fields(input req_t r, input bit is_last);
        req_op = r.op; req_rs = r.rs; req_rt = r.rt; req_rd = r.rd;
        req_shamt = r.shamt; req_funct = r.funct; req_imm = r.imm;
        req_last = is_last;
    endtask

    task automatic drive_req(input req_t r, input bit is_last);
        set_fields(r, is_last);
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        timed_out = 1;
    endtask

    task automatic run_session(input bit [31:0] base, input req_t reqs[$]);
        obs_addr.delete();
        obs_data.delete();
        timed_out   = 0;
        done_cycles = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        set_fields(reqs[0], reqs.size() == 1);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = $urandom;
        foreach (reqs[i]) drive_req(reqs[i], i == reqs.size() - 1);
        req_valid = 1'b0;
        req_last  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) done_cycles++;
            else if (done_cycles > 0) break;
        end
        if (done_cycles == 0) timed_out = 1;
        got_count = int'(count);
        got_err   = err;
        got_busy  = busy;
        checks++;
        if (timed_out) begin
            failures++;
            $display("[TB] FAIL session_timeout got=timeout want=completion");
        end
    endtask

    function automatic req_t mk(input int op, input int rs, input int rt, input int rd,
                                input int sh, input int fn, input int imm);
        req_t r;
        r.op = 3'(op); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
        r.shamt = 5'(sh); r.funct = 6'(fn); r.imm = 16'(imm);
        return r;
    endfunction

    function automatic req_t rand_req(input int illegal_pct);
        req_t r;
        r.op = ($urandom_range(0, 99) < illegal_pct) ? 3'd7 : 3'($urandom_range(0, 6));
        r.rs = 5'($urandom); r.rt = 5'($urandom); r.rd = 5'($urandom);
        r.shamt = 5'($urandom); r.funct = 6'($urandom); r.imm = 16'($urandom);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (im_we !== 1'b0)     begin failures++; $display("[TB] FAIL reset_im_we got=%b want=0", im_we); end
        checks++; if (im_addr !== 32'd0)  begin failures++; $display("[TB] FAIL reset_im_addr got=%h want=0", im_addr); end
        checks++; if (im_wdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_im_wdata got=%h want=0", im_wdata); end
        checks++; if (count !== 4'd0)     begin failures++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0)      begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        checks++; if (err !== 1'b0)       begin failures++; $display("[TB] FAIL reset_err got=%b want=0", err); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b want=0", req_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_addi_single();
        req_t q[$];
        q.push_back(mk(1, 1, 2, 0, 0, 0, 16'h0005));
        run_session(32'h40, q);
        checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 32'h40 || obs_data[0] !== 32'h2022_0005) begin
            failures++;
            $display("[TB] FAIL addi_write got=n%0d %h@%h want=n1 20220005@00000040",
                     obs_addr.size(), obs_addr.size() ? obs_data[0] : 0, obs_addr.size() ? obs_addr[0] : 0);
        end
        checks++; if (got_count != 1)  begin failures++; $display("[TB] FAIL addi_count got=%0d want=1", got_count); end
        checks++; if (done_cycles != 1) begin failures++; $display("[TB] FAIL addi_done_width got=%0d want=1", done_cycles); end
        checks++; if (got_err !== 1'b0) begin failures++; $display("[TB] FAIL addi_err got=%b want=0", got_err); end
        checks++; if (got_busy !== 1'b0) begin failures++; $display("[TB] FAIL addi_busy_after got=%b want=0", got_busy); end
    endtask

    task automatic test_rtype_beq();
        req_t q[$];
        q.push_back(mk(0, 1, 2, 3, 0, 6'h20, 0));
        q.push_back(mk(3, 3, 0, 0, 0, 0, 16'hFFFF));
        run_session(32'h0000_0003, q);
        checks++;
        if (obs_addr.size() != 2) begin
            failures++;
            $display("[TB] FAIL rbeq_nwrites got=%0d want=2", obs_addr.size());
        end else begin
            checks++;
            if (obs_addr[0] !== 32'h0 || obs_data[0] !== 32'h0022_1820) begin
                failures++;
                $display("[TB] FAIL rtype_word got=%h@%h want=00221820@00000000", obs_data[0], obs_addr[0]);
            end
            checks++;
            if (obs_addr[1] !== 32'h4 || obs_data[1] !== 32'h1060_FFFF) begin
                failures++;
                $display("[TB] FAIL beq_word got=%h@%h want=1060ffff@00000004", obs_data[1], obs_addr[1]);
            end
        end
        checks++; if (got_count != 2) begin failures++; $display("[TB] FAIL rbeq_count got=%0d want=2", got_count); end
    endtask

    task automatic test_lui();
        req_t q[$];
        q.push_back(mk(4, 7, 4, 0, 0, 0, 16'h1234));
        run_session(32'h100, q);
        checks++;
        if (obs_data.size() != 1 || obs_data[0] !== 32'h3C04_1234) begin
            failures++;
            $display("[TB] FAIL lui_word got=n%0d %h want=n1 3c041234",
                     obs_data.size(), obs_data.size() ? obs_data[0] : 0);
        end
    endtask

    task automatic test_stall();
        req_t q[$];
        for (int i = 0; i < 6; i++) q.push_back(rand_req(0));
        model_session(32'h200, q);
        hold_viol = 0;
        bp_viol   = 0;
        expect_bp = 1;
        ready_prob = 100;
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                stall_req = 3;
            end
        join_none
        run_session(32'h200, q);
        expect_bp = 0;
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            failures++;
            $display("[TB] FAIL stall_nwrites got=%0d want=%0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                failures++;
                $display("[TB] FAIL stall_write%0d got=%h@%h want=%h@%h", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
            end
        end
        checks++; if (hold_viol != 0) begin failures++; $display("[TB] FAIL stall_hold got=%0d want=0", hold_viol); end
        checks++; if (bp_viol != 0)   begin failures++; $display("[TB] FAIL stall_ready got=%0d want=0", bp_viol); end
    endtask

    task automatic test_illegal();
        req_t q[$];
        q.push_back(rand_req(0));
        q.push_back(mk(7, 1, 1, 1, 1, 1, 1));
        q.push_back(mk(5, 9, 10, 0, 0, 0, 16'hBEEF));
        q.push_back(mk(7, 2, 2, 2, 2, 2, 2));
        model_session(32'h80, q);
        ready_prob = 70;
        run_session(32'h80, q);
        ready_prob = 100;
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            failures++;
            $display("[TB] FAIL illegal_nwrites got=%0d want=%0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                failures++;
                $display("[TB] FAIL illegal_write%0d got=%h@%h want=%h@%h", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
            end
        end
        checks++; if (got_err !== exp_err)   begin failures++; $display("[TB] FAIL illegal_err got=%b want=%b", got_err, exp_err); end
        checks++; if (got_count != exp_count) begin failures++; $display("[TB] FAIL illegal_count got=%0d want=%0d", got_count, exp_count); end
    endtask

    task automatic test_overflow();
        req_t q[$];
        for (int i = 0; i < TB_DEPTH + 2; i++) q.push_back(rand_req(0));
        model_session(32'h1000, q);
        ready_prob = 80;
        run_session(32'h1000, q);
        ready_prob = 100;
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            failures++;
            $display("[TB] FAIL ovf_nwrites got=%0d want=%0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                failures++;
                $display("[TB] FAIL ovf_write%0d got=%h@%h want=%h@%h", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
            end
        end
        checks++; if (got_err !== exp_err)    begin failures++; $display("[TB] FAIL ovf_err got=%b want=%b", got_err, exp_err); end
        checks++; if (got_count != exp_count) begin failures++; $display("[TB] FAIL ovf_count got=%0d want=%0d", got_count, exp_count); end
        checks++; if (done_cycles != 1)       begin failures++; $display("[TB] FAIL ovf_done_width got=%0d want=1", done_cycles); end
    endtask

    task automatic test_random();
        req_t q[$];
        bit [31:0] base;
        int n;
        hold_viol = 0;
        for (int s = 0; s < 6; s++) begin
            q.delete();
            n = $urandom_range(1, TB_DEPTH + 3);
            for (int k = 0; k < n; k++) q.push_back(rand_req(10));
            base = (s == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            ready_prob = $urandom_range(30, 100);
            model_session(base, q);
            run_session(base, q);
            checks++;
            if (obs_addr.size() != exp_addr.size()) begin
                failures++;
                $display("[TB] FAIL rand%0d_nwrites got=%0d want=%0d", s, obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_write%0d got=%h@%h want=%h@%h", s, i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
                end
            end
            checks++; if (got_err !== exp_err)    begin failures++; $display("[TB] FAIL rand%0d_err got=%b want=%b", s, got_err, exp_err); end
            checks++; if (got_count != exp_count) begin failures++; $display("[TB] FAIL rand%0d_count got=%0d want=%0d", s, got_count, exp_count); end
        end
        ready_prob = 100;
        checks++; if (hold_viol != 0)       begin failures++; $display("[TB] FAIL rand_hold got=%0d want=0", hold_viol); end
        checks++; if (idle_ready_viol != 0) begin failures++; $display("[TB] FAIL ready_outside_session got=%0d want=0", idle_ready_viol); end
    endtask

    task automatic test_reset_mid_load();
        req_t r;
        timed_out  = 0;
        ready_prob = 0;
        r = rand_req(0);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 32'h300;
        @(posedge clk);
        #1;
        start = 1'b0;
        drive_req(r, 1'b0);
        r = rand_req(0);
        set_fields(r, 1'b0);
        @(negedge clk);
        checks++;
        if (im_we !== 1'b1 || busy !== 1'b1 || timed_out) begin
            failures++;
            $display("[TB] FAIL midload_pending got=we%b busy%b want=we1 busy1", im_we, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL midload_busy got=%b want=0", busy); end
        checks++; if (im_we !== 1'b0)     begin failures++; $display("[TB] FAIL midload_im_we got=%b want=0", im_we); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL midload_ready got=%b want=0", req_ready); end
        checks++; if (count !== 4'd0)     begin failures++; $display("[TB] FAIL midload_count got=%0d want=0", count); end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req_valid  = 1'b0;
        ready_prob = 100;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; req_valid = 1'b0;
        req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0;
        req_funct = '0; req_imm = '0; req_last = 1'b0;
        test_reset();
        test_addi_single();
        test_rtype_beq();
        test_lui();
        test_stall();
        test_illegal();
        test_overflow();
        test_random();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
